// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline-stage register: FSM state
// encoding and the control-bundle width used at each core boundary.
package pipe_pkg;

  // Occupancy of the stage: main register only, or main plus skid entry.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // Inter-stage boundaries of the core.
  typedef enum logic [1:0] {
    BND_IF_ID  = 2'd0,
    BND_ID_EX  = 2'd1,
    BND_EX_MEM = 2'd2,
    BND_MEM_WB = 2'd3
  } boundary_e;

  // Control-bundle width carried across each boundary; instantiating
  // stages use this to size NB_CTRL consistently.
  function automatic int unsigned stage_ctrl_width(boundary_e b);
    int unsigned w;
    w = 9;
    case (b)
      BND_IF_ID:  w = 4;
      BND_ID_EX:  w = 9;
      BND_EX_MEM: w = 6;
      BND_MEM_WB: w = 3;
      default:    w = 9;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment
// and the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int NB_CNT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [NB_CNT-1:0] cnt
);

  // Count register: async reset, clear priority, saturate at max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {NB_CNT{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, synchronous
// flush with bubble injection and a saturating stall counter.
//
// Handshake: a beat moves on a side only in a cycle where both valid and
// ready are high on that side (in_fire = i_valid & o_ready, out_fire =
// o_valid & i_ready). Valid never depends on ready in the same cycle, and
// o_ready/o_valid are decoded straight from the state register, so there is
// no combinational path from i_ready to o_ready.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int                 NB_CTRL            = 9,
  parameter int                 NB_DATA            = 128,
  parameter logic [NB_CTRL-1:0] CTRL_BUBBLE        = {NB_CTRL{1'b0}},
  parameter int                 ZERO_DATA_ON_FLUSH = 0,
  parameter int                 NB_CNT             = 16
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_CTRL-1:0] i_ctrl,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic [NB_DATA-1:0] o_data,
  input  logic               i_flush,
  input  logic               i_clr_cnt,
  output logic [NB_CNT-1:0]  o_stall_cnt,
  output state_e             o_dbg_state
);

  localparam bit ZERO_DATA = (ZERO_DATA_ON_FLUSH != 0);

  state_e             state_q, state_d;
  logic [NB_CTRL-1:0] main_ctrl_q, main_ctrl_d;
  logic [NB_DATA-1:0] main_data_q, main_data_d;
  logic [NB_CTRL-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [NB_DATA-1:0] skid_data_q, skid_data_d;
  logic [NB_DATA-1:0] bubble_data;
  logic               in_fire;
  logic               out_fire;

  assign o_valid     = (state_q != ST_EMPTY);
  assign o_ready     = (state_q != ST_SKID);
  assign o_ctrl      = main_ctrl_q;
  assign o_data      = main_data_q;
  assign o_dbg_state = state_q;

  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  // Payload left in the main register when it turns into a bubble.
  assign bubble_data = ZERO_DATA ? '0 : main_data_q;

  // Next-state and datapath selection; flush overrides every transfer.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (i_flush) begin
      // Held and incoming entries are discarded; a downstream accept in
      // this cycle has already consumed the current output.
      state_d     = ST_EMPTY;
      main_ctrl_d = CTRL_BUBBLE;
      main_data_d = bubble_data;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_ctrl_d = i_ctrl;
            main_data_d = i_data;
            state_d     = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = i_ctrl;
            main_data_d = i_data;
          end else if (out_fire) begin
            main_ctrl_d = CTRL_BUBBLE;
            main_data_d = bubble_data;
            state_d     = ST_EMPTY;
          end else if (in_fire) begin
            // Output is stalled, so the new beat parks in the skid slot.
            skid_ctrl_d = i_ctrl;
            skid_data_d = i_data;
            state_d     = ST_SKID;
          end
        end
        ST_SKID: begin
          // The skid entry is older than anything upstream, so it always
          // moves into main before new input is taken.
          if (out_fire) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
            skid_data_d = '0;
            state_d     = ST_FULL;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ctrl_d = CTRL_BUBBLE;
          main_data_d = '0;
          skid_ctrl_d = '0;
          skid_data_d = '0;
        end
      endcase
    end
  end

  // State and datapath registers; reset drops every entry at once.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= CTRL_BUBBLE;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Cycles where a valid output is held back by the consumer.
  sat_counter #(
    .NB_CNT (NB_CNT)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (i_rst_n),
    .inc   (o_valid & ~i_ready),
    .clr   (i_clr_cnt),
    .cnt   (o_stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: two instances share the stimulus, one
// holding payload on bubbles and one zeroing it. The reference model is a
// FIFO of at most two beats plus a saturating counter.
module tb_pipe_stage_skid_reg;
  import pipe_pkg::*;

  localparam int                 NB_CTRL = 9;
  localparam int                 NB_DATA = 128;
  localparam int                 NB_CNT  = 4;
  localparam logic [NB_CTRL-1:0] BUBBLE  = 9'h013;
  localparam int                 CNT_MAX = (1 << NB_CNT) - 1;
  localparam int                 W       = NB_CTRL + NB_DATA;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               i_rst_n = 1'b0;
  logic               i_valid = 1'b0;
  logic [NB_CTRL-1:0] i_ctrl  = '0;
  logic [NB_DATA-1:0] i_data  = '0;
  logic               i_ready = 1'b0;
  logic               i_flush = 1'b0;
  logic               i_clr_cnt = 1'b0;

  logic               o_ready0, o_valid0, o_readyz, o_validz;
  logic [NB_CTRL-1:0] o_ctrl0, o_ctrlz;
  logic [NB_DATA-1:0] o_data0, o_dataz;
  logic [NB_CNT-1:0]  o_cnt0, o_cntz;
  state_e             st0, stz;

  pipe_stage_skid_reg #(
    .NB_CTRL(NB_CTRL), .NB_DATA(NB_DATA), .CTRL_BUBBLE(BUBBLE),
    .ZERO_DATA_ON_FLUSH(0), .NB_CNT(NB_CNT)
  ) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready0),
    .i_ctrl(i_ctrl), .i_data(i_data), .o_valid(o_valid0), .i_ready(i_ready),
    .o_ctrl(o_ctrl0), .o_data(o_data0), .i_flush(i_flush),
    .i_clr_cnt(i_clr_cnt), .o_stall_cnt(o_cnt0), .o_dbg_state(st0)
  );

  pipe_stage_skid_reg #(
    .NB_CTRL(NB_CTRL), .NB_DATA(NB_DATA), .CTRL_BUBBLE(BUBBLE),
    .ZERO_DATA_ON_FLUSH(1), .NB_CNT(NB_CNT)
  ) dut_z (
    .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_readyz),
    .i_ctrl(i_ctrl), .i_data(i_data), .o_valid(o_validz), .i_ready(i_ready),
    .o_ctrl(o_ctrlz), .o_data(o_dataz), .i_flush(i_flush),
    .i_clr_cnt(i_clr_cnt), .o_stall_cnt(o_cntz), .o_dbg_state(stz)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0]       exp_q[$];
  logic [W-1:0]       pend_item = '0;
  logic               pend_push = 1'b0;
  int                 exp_cnt   = 0;
  logic [NB_DATA-1:0] last_data = '0;
  logic               mon_en    = 1'b0;
  int                 n_checks  = 0;
  int                 n_errors  = 0;

  task automatic chk(input string name, input logic [NB_DATA-1:0] act,
                     input logic [NB_DATA-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of inputs just after the rising edge. A beat accepted
  // in the previous cycle joins the expected queue at this edge; whether
  // the new beat is accepted follows from the model occupancy alone.
  task automatic drive(input logic v, input logic [NB_CTRL-1:0] c,
                       input logic [NB_DATA-1:0] d, input logic rdy,
                       input logic fl, input logic clr);
    @(posedge clk);
    #1;
    if (pend_push) exp_q.push_back(pend_item);
    i_valid   = v;
    i_ctrl    = c;
    i_data    = d;
    i_ready   = rdy;
    i_flush   = fl;
    i_clr_cnt = clr;
    pend_push = v && (exp_q.size() < 2) && !fl;
    pend_item = {c, d};
  endtask

  function automatic logic [NB_DATA-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- monitor ----------------
  // Compares both instances against the model mid-cycle, then retires the
  // beat that leaves this cycle and applies flush and counter updates.
  always @(negedge clk) begin
    int sz;
    logic [NB_CTRL-1:0] ec;
    logic [NB_DATA-1:0] ed;
    if (mon_en) begin
      sz = exp_q.size();
      chk("valid", {127'd0, o_valid0}, {127'd0, sz > 0});
      chk("valid_z", {127'd0, o_validz}, {127'd0, sz > 0});
      chk("ready", {127'd0, o_ready0}, {127'd0, sz < 2});
      chk("ready_z", {127'd0, o_readyz}, {127'd0, sz < 2});
      chk("state", NB_DATA'(int'(st0)), NB_DATA'(sz));
      chk("stall_cnt", NB_DATA'(o_cnt0), NB_DATA'(exp_cnt));
      chk("stall_cnt_z", NB_DATA'(o_cntz), NB_DATA'(exp_cnt));
      if (sz > 0) begin
        ec = exp_q[0][NB_DATA +: NB_CTRL];
        ed = exp_q[0][NB_DATA-1:0];
        chk("ctrl", NB_DATA'(o_ctrl0), NB_DATA'(ec));
        chk("ctrl_z", NB_DATA'(o_ctrlz), NB_DATA'(ec));
        chk("data", o_data0, ed);
        chk("data_z", o_dataz, ed);
        last_data = ed;
      end else begin
        chk("bubble_ctrl", NB_DATA'(o_ctrl0), NB_DATA'(BUBBLE));
        chk("bubble_ctrl_z", NB_DATA'(o_ctrlz), NB_DATA'(BUBBLE));
        chk("bubble_data_hold", o_data0, last_data);
        chk("bubble_data_zero", o_dataz, '0);
      end
      if (i_clr_cnt) exp_cnt = 0;
      else if (sz > 0 && !i_ready && exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
      if (sz > 0 && i_ready) void'(exp_q.pop_front());
      if (i_flush) exp_q.delete();
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #2;
    i_rst_n = 1'b1;
    mon_en  = 1'b1;

    // Streaming at full rate.
    drive(1, 9'h1A5, rnd_data(), 1, 0, 0);
    drive(1, 9'h0F3, rnd_data(), 1, 0, 0);
    drive(1, 9'h101, rnd_data(), 1, 0, 0);
    drive(0, 9'h000, '0, 1, 0, 0);
    drive(0, 9'h000, '0, 1, 0, 0);

    // Skid fill under backpressure, then drain in order.
    drive(1, 9'h0AA, rnd_data(), 0, 0, 0);
    drive(1, 9'h0BB, rnd_data(), 0, 0, 0);
    drive(1, 9'h0CC, rnd_data(), 0, 0, 0);
    drive(0, 9'h000, '0, 0, 0, 0);
    repeat (3) drive(0, 9'h000, '0, 1, 0, 0);

    // Flush while in SKID with a new beat offered in the same cycle.
    drive(1, 9'h0A1, rnd_data(), 0, 0, 0);
    drive(1, 9'h0B2, rnd_data(), 0, 0, 0);
    drive(0, 9'h000, '0, 0, 0, 0);
    drive(1, 9'h0C3, rnd_data(), 0, 1, 0);
    repeat (2) drive(0, 9'h000, '0, 1, 0, 0);

    // Asynchronous reset while FULL, checked before the next edge.
    drive(1, 9'h055, rnd_data(), 0, 0, 0);
    drive(0, 9'h000, '0, 0, 0, 0);
    @(posedge clk);
    #1;
    mon_en    = 1'b0;
    pend_push = 1'b0;
    i_valid   = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_valid", {127'd0, o_valid0}, '0);
    chk("rst_ctrl", NB_DATA'(o_ctrl0), NB_DATA'(BUBBLE));
    chk("rst_ready", {127'd0, o_ready0}, {127'd0, 1'b1});
    chk("rst_data", o_data0, '0);
    chk("rst_cnt", NB_DATA'(o_cnt0), '0);
    exp_q.delete();
    exp_cnt   = 0;
    last_data = '0;
    repeat (2) @(posedge clk);
    #2;
    i_rst_n = 1'b1;
    mon_en  = 1'b1;
    drive(1, 9'h066, rnd_data(), 1, 0, 0);
    drive(0, 9'h000, '0, 1, 0, 0);

    // Stall counter saturation, then clear together with a stall.
    drive(1, 9'h077, rnd_data(), 0, 0, 0);
    repeat (20) drive(0, 9'h000, '0, 0, 0, 0);
    drive(0, 9'h000, '0, 0, 0, 1);
    drive(0, 9'h000, '0, 0, 0, 0);
    repeat (2) drive(0, 9'h000, '0, 1, 0, 0);

    // Randomised traffic with occasional flush and counter clear.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 70, 9'($urandom_range(0, 511)), rnd_data(),
            $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 5);
    end
    repeat (4) drive(0, 9'h000, '0, 1, 0, 0);
    @(posedge clk);
    #1;
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
